// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: stage 1 registers the operand set, stage 2 registers
// the result and NZCV flags. Also keeps a wrapping count of delivered results.
module alu_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic [CNT_W-1:0] OpCount
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;
  logic [2:0]       s1_op_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       flags_r;
  logic [CNT_W-1:0] count_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             sub_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] sum_s;
  logic             carry_s;
  logic             ovf_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;

  // Each stage moves when empty or when the stage after it moves this cycle.
  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s && !rst;

  assign out_valid = s2_valid_r;
  assign ALUResult = result_r;
  assign ALUFlags  = flags_r;
  assign OpCount   = count_r;

  // Shared adder: SUB is A + ~B + 1, carry out doubles as the no-borrow flag.
  always_comb begin
    sub_s            = (s1_op_r == OP_SUB);
    b_op_s           = sub_s ? ~s1_b_r : s1_b_r;
    {carry_s, sum_s} = {1'b0, s1_a_r} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sub_s};
    ovf_s            = (s1_a_r[WIDTH-1] == b_op_s[WIDTH-1]) &&
                       (sum_s[WIDTH-1] != s1_a_r[WIDTH-1]);
  end

  // Operation select; logical, compare and shift ops clear C and V.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (s1_op_r)
      OP_ADD, OP_SUB: begin
        res_s = sum_s;
        c_s   = carry_s;
        v_s   = ovf_s;
      end
      OP_AND:  res_s = s1_a_r & s1_b_r;
      OP_OR:   res_s = s1_a_r | s1_b_r;
      OP_XOR:  res_s = s1_a_r ^ s1_b_r;
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(s1_a_r) < $signed(s1_b_r))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (s1_a_r < s1_b_r)};
      OP_SLL:  res_s = s1_a_r << s1_b_r[SH_W-1:0];
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
      s1_op_r    <= 3'b000;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_a_r  <= SrcA;
        s1_b_r  <= SrcB;
        s1_op_r <= ALUControl;
      end
    end
  end

  // Stage 2: result and flags; held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      flags_r    <= 4'b0000;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_s;
        flags_r  <= {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_s, v_s};
      end
    end
  end

  // Delivered-result counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (s2_valid_r && out_ready) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table streamed back-to-back, plus latency,
// backpressure, mid-operation reset and counter-wrap sequences.
module tb_alu_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] SrcA;
  logic [63:0] SrcB;
  logic [2:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic [3:0]  OpCount;

  alu_pipe #(.WIDTH(64), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .ALUFlags(ALUFlags), .OpCount(OpCount)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_cnt = 4'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
  endtask

  task automatic run_table();
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("tbl_valid", {63'd0, out_valid}, 64'd1);
        chk("tbl_res", ALUResult, tbl[i-2].res);
        chk("tbl_flags", {60'd0, ALUFlags}, {60'd0, tbl[i-2].flg});
        exp_cnt = exp_cnt + 4'd1;
      end
      chk("tbl_in_ready", {63'd0, in_ready}, 64'd1);
      if (i < NV) drive(tbl[i].op, tbl[i].a, tbl[i].b);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    chk("tbl_drain", {63'd0, out_valid}, 64'd0);
    chk("tbl_count", {60'd0, OpCount}, {60'd0, exp_cnt});
  endtask

  initial begin
    tbl[0]  = '{3'b000, 64'd105, 64'd215, 64'd320, 4'b0000};
    tbl[1]  = '{3'b001, 64'd105, 64'd105, 64'd0, 4'b0110};
    tbl[2]  = '{3'b010, 64'd105, 64'd215, 64'd65, 4'b0000};
    tbl[3]  = '{3'b011, 64'd105, 64'd215, 64'd255, 4'b0000};
    tbl[4]  = '{3'b100, 64'd105, 64'd215, 64'd190, 4'b0000};
    tbl[5]  = '{3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001};
    tbl[6]  = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 4'b0000};
    tbl[7]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0100};
    tbl[8]  = '{3'b111, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000};
    tbl[9]  = '{3'b001, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    tbl[10] = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110};
    tbl[11] = '{3'b001, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    tbl[12] = '{3'b111, 64'd1, 64'd67, 64'd8, 4'b0000};
    tbl[13] = '{3'b101, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0100};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = 64'd0; SrcB = 64'd0; ALUControl = 3'b000;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_count", {60'd0, OpCount}, 64'd0);
    chk("rst_result", ALUResult, 64'd0);
    chk("rst_flags", {60'd0, ALUFlags}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Single-op latency: valid appears on the second edge after acceptance.
    @(negedge clk);
    drive(3'b000, 64'd105, 64'd215);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_res", ALUResult, 64'd320);
    chk("lat_flags", {60'd0, ALUFlags}, 64'd0);
    exp_cnt = exp_cnt + 4'd1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_drain", {63'd0, out_valid}, 64'd0);

    // Two full passes: 1 + 14 + 14 handshakes wraps the 4-bit counter.
    run_table();
    run_table();

    // Reset with both stages occupied.
    out_ready = 1'b0;
    @(negedge clk); drive(3'b000, 64'd1, 64'd2);
    @(negedge clk); drive(3'b011, 64'd4, 64'd8);
    @(negedge clk); in_valid = 1'b0;
    chk("mid_full", {63'd0, out_valid}, 64'd1);
    chk("mid_stall", {63'd0, in_ready}, 64'd0);
    chk("mid_count", {60'd0, OpCount}, {60'd0, exp_cnt});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_count", {60'd0, OpCount}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mid_rst_result", ALUResult, 64'd0);
    chk("mid_rst_flags", {60'd0, ALUFlags}, 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; exp_cnt = 4'd0;
    #1;
    chk("mid_rel_in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_stale", {63'd0, out_valid}, 64'd0);
    end
    chk("mid_count_after", {60'd0, OpCount}, 64'd0);

    // Backpressure: A and B fill the pipe, C waits until the consumer frees it.
    out_ready = 1'b0;
    @(negedge clk); drive(3'b000, 64'd105, 64'd215);
    chk("bp_acc_a", {63'd0, in_ready}, 64'd1);
    @(negedge clk); drive(3'b001, 64'd105, 64'd105);
    chk("bp_acc_b", {63'd0, in_ready}, 64'd1);
    @(negedge clk); drive(3'b011, 64'd105, 64'd215);
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_full_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_hold_a", ALUResult, 64'd320);
    @(negedge clk);
    chk("bp_still_full", {63'd0, in_ready}, 64'd0);
    chk("bp_still_a", ALUResult, 64'd320);
    chk("bp_still_flags", {60'd0, ALUFlags}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_out_b", ALUResult, 64'd0);
    chk("bp_flags_b", {60'd0, ALUFlags}, 64'd6);
    chk("bp_valid_b", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp_out_c", ALUResult, 64'd255);
    chk("bp_valid_c", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("bp_drain", {63'd0, out_valid}, 64'd0);
    chk("bp_count", {60'd0, OpCount}, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits; SHALL support any value from 8 to 64.
REQ-002 Parameter CNT_W, default 32, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on SrcA/SrcB/ALUControl is valid.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B; for SLL, the shift amount is SrcB[$clog2(WIDTH)-1:0].
REQ-009 ALUControl  input  3  operation select.
REQ-010 out_valid  output  1  ALUResult/ALUFlags hold a completed result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 ALUResult  output  WIDTH  registered result.
REQ-013 ALUFlags  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.
REQ-014 OpCount  output  CNT_W  number of output handshakes since reset.

Function
REQ-015 ALUControl decode SHALL be:
- 000 ADD
- 001 SUB
- 010 AND
- 011 OR
- 100 XOR
- 101 SLT (signed A<B -> 1, else 0)
- 110 SLTU (unsigned A<B -> 1, else 0)
- 111 SLL (A << shamt, zero fill)
REQ-016 An input handshake SHALL occur when in_valid && in_ready; an output handshake SHALL occur when out_valid && out_ready.
REQ-017 The pipeline SHALL have two register stages: S1 captures SrcA, SrcB and ALUControl; S2 captures the computed ALUResult and ALUFlags.
REQ-018 With out_ready held high, out_valid SHALL rise exactly 2 cycles after the input handshake edge, and the pipeline SHALL sustain one operation per cycle.
REQ-019 Each stage SHALL advance when it is empty or when its downstream stage advances in the same cycle.
REQ-020 in_ready SHALL equal !S1_valid || S1 advancing, derived combinationally from out_ready; there are no bubbles under continuous flow.
REQ-021 While out_valid && !out_ready, ALUResult, ALUFlags and out_valid SHALL hold stable.
REQ-022 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.
REQ-023 Arithmetic SHALL be WIDTH bits, modulo 2^WIDTH; SUB is A + ~B + 1.
REQ-024 N SHALL be ALUResult[WIDTH-1], and Z SHALL be (ALUResult == 0), for every op.
REQ-025 For ADD, C SHALL be the carry out of the MSB; for SUB, C SHALL be the carry out (1 = no borrow).
REQ-026 For ADD and SUB, V SHALL be the signed overflow of the operation.
REQ-027 For AND, OR, XOR, SLT, SLTU and SLL, C and V SHALL be 0.
REQ-028 OpCount SHALL increment by 1 on each output handshake and wrap from 2^CNT_W-1 to 0.
REQ-029 With the pipeline full and out_ready low, in_ready SHALL be 0; a simultaneous output handshake and input handshake SHALL both complete in the same cycle.

Reset
REQ-030 While rst is high, out_valid, in_ready, both stage-valid flags, ALUResult, ALUFlags and OpCount SHALL be 0, taking effect immediately without waiting for clk.
REQ-031 Operations in flight when rst asserts SHALL be discarded; none SHALL emerge after reset.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=64, out_ready=1 unless stated)
REQ-033 ADD: SrcA=105, SrcB=215 -> ALUResult=320, ALUFlags=4'b0000, out_valid 2 cycles after accept.
REQ-034 SUB: SrcA=105, SrcB=105 -> ALUResult=0, ALUFlags=4'b0110; AND of 105 and 215 -> 65; OR of 105 and 215 -> 255.
REQ-035 ADD: SrcA=64'h7FFF_FFFF_FFFF_FFFF, SrcB=1 -> ALUResult=64'h8000_0000_0000_0000, ALUFlags=4'b1001.
REQ-036 SLT: SrcA=-1, SrcB=1 -> 1; SLTU with the same operands -> 0; SLL with SrcA=1, SrcB=63 -> 64'h8000_0000_0000_0000, N=1.
REQ-037 Backpressure: out_ready=0 with ops A, B, C offered back-to-back -> A, B accepted, in_ready=0, ALUResult holds A; then out_ready=1 -> A, B, C delivered on consecutive cycles; OpCount=3.
REQ-038 Reset mid-op: assert rst with both stages valid -> out_valid=0 and OpCount=0 before the next clk edge; no stale result after release.
